// File: rtl/mem_access_initiator.sv
// Initiator side of the single-port memory request/valid protocol.
// Takes one load/store command at a time from the load/store stage and turns
// it into one or two memory accesses. Sub-word stores are done as
// read-modify-write. Misaligned accesses, illegal sizes and memory timeouts
// come back as error responses.
//
// Handshakes: a command transfers on a clk edge where req_valid & req_ready,
// and a response transfers on a clk edge where resp_valid & resp_ready. Once
// resp_valid is raised, it and every resp_* output stay unchanged until that
// transfer. On the memory side, mem_request/mem_we/mem_addr/mem_wdata stay
// unchanged until a clk edge with mem_valid = 1 or a timeout. mem_request
// then drops for at least one cycle before the next access.
module mem_access_initiator #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [1:0]                req_size,
  input  logic                      req_unsigned,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [DATA_WIDTH-1:0]     resp_rdata,
  output logic                      resp_err,
  output logic                      mem_request,
  output logic                      mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  input  logic                      mem_valid,
  input  logic [DATA_WIDTH-1:0]     mem_rdata
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_GAP  = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Current FSM state. It is kept as a named signal so that checkers can bind to it.
  logic [2:0]            state;

  // Latched command fields. The upper address bits are kept in mem_addr.
  logic                  cmd_we;
  logic [1:0]            cmd_size;
  logic                  cmd_unsigned;
  logic [1:0]            cmd_lane;
  logic [15:0]           cmd_wdata;

  logic [DATA_WIDTH-1:0] rd_word;
  logic [CNT_W-1:0]      tmo_cnt;

  logic                  bad_cmd;
  logic [MEM_ADDR_WIDTH-1:0] addr_word;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [DATA_WIDTH-1:0] load_ext;
  logic [DATA_WIDTH-1:0] merged_word;

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);

  // The word address is req_addr >> 2. It is zero-extended or truncated to
  // the memory-side width.
  if (MEM_ADDR_WIDTH >= ADDR_WIDTH - 2) begin : g_addr_ext
    assign addr_word = MEM_ADDR_WIDTH'(req_addr[ADDR_WIDTH-1:2]);
  end else begin : g_addr_trunc
    assign addr_word = req_addr[MEM_ADDR_WIDTH+1:2];
  end

  // Reject illegal sizes and accesses that are not naturally aligned before
  // any memory access is made.
  always_comb begin
    bad_cmd = 1'b0;
    case (req_size)
      SZ_BYTE: bad_cmd = 1'b0;
      SZ_HALF: bad_cmd = req_addr[0];
      SZ_WORD: bad_cmd = (req_addr[1:0] != 2'b00);
      default: bad_cmd = 1'b1;
    endcase
  end

  // Pick the addressed byte or half from the returned word and extend it.
  // req_unsigned has no effect on word loads.
  always_comb begin
    ld_byte  = mem_rdata[{cmd_lane, 3'b000} +: 8];
    ld_half  = cmd_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_ext = mem_rdata;
    case (cmd_size)
      SZ_BYTE: load_ext = {{24{~cmd_unsigned & ld_byte[7]}}, ld_byte};
      SZ_HALF: load_ext = {{16{~cmd_unsigned & ld_half[15]}}, ld_half};
      default: load_ext = mem_rdata;
    endcase
  end

  // Put the new byte or half into the word that was read for a sub-word store.
  always_comb begin
    merged_word = rd_word;
    if (cmd_size == SZ_BYTE) begin
      merged_word[{cmd_lane, 3'b000} +: 8] = cmd_wdata[7:0];
    end else if (cmd_lane[1]) begin
      merged_word[31:16] = cmd_wdata;
    end else begin
      merged_word[15:0] = cmd_wdata;
    end
  end

  // Main access sequencer: command capture, memory accesses, timeout and response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      mem_request  <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      resp_rdata   <= '0;
      resp_err     <= 1'b0;
      tmo_cnt      <= '0;
      cmd_we       <= 1'b0;
      cmd_size     <= 2'b00;
      cmd_unsigned <= 1'b0;
      cmd_lane     <= 2'b00;
      cmd_wdata    <= '0;
      rd_word      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            cmd_we       <= req_we;
            cmd_size     <= req_size;
            cmd_unsigned <= req_unsigned;
            cmd_lane     <= req_addr[1:0];
            cmd_wdata    <= req_wdata[15:0];
            mem_addr     <= addr_word;
            tmo_cnt      <= '0;
            if (bad_cmd) begin
              state      <= S_RESP;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else if (req_we && (req_size == SZ_WORD)) begin
              state       <= S_WR;
              mem_request <= 1'b1;
              mem_we      <= 1'b1;
              mem_wdata   <= req_wdata;
            end else begin
              state       <= S_RD;
              mem_request <= 1'b1;
              mem_we      <= 1'b0;
            end
          end
        end

        S_RD: begin
          if (mem_valid) begin
            mem_request <= 1'b0;
            if (cmd_we) begin
              rd_word <= mem_rdata;
              state   <= S_GAP;
            end else begin
              resp_rdata <= load_ext;
              resp_err   <= 1'b0;
              state      <= S_RESP;
            end
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
            if (tmo_cnt == TMO_LAST) begin
              mem_request <= 1'b0;
              resp_rdata  <= '0;
              resp_err    <= 1'b1;
              state       <= S_RESP;
            end
          end
        end

        // One idle cycle lets the responder drop its valid before the write.
        S_GAP: begin
          mem_wdata   <= merged_word;
          mem_request <= 1'b1;
          mem_we      <= 1'b1;
          state       <= S_WR;
        end

        S_WR: begin
          if (mem_valid) begin
            mem_request <= 1'b0;
            mem_we      <= 1'b0;
            resp_rdata  <= '0;
            resp_err    <= 1'b0;
            state       <= S_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
            if (tmo_cnt == TMO_LAST) begin
              mem_request <= 1'b0;
              mem_we      <= 1'b0;
              resp_rdata  <= '0;
              resp_err    <= 1'b1;
              state       <= S_RESP;
            end
          end
        end

        S_RESP: begin
          if (resp_ready) begin
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            state      <= S_IDLE;
          end
        end

        default: begin
          mem_request <= 1'b0;
          mem_we      <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_initiator.sv
// Bench for mem_access_initiator. The memory responder has a configurable
// number of stall cycles and can inject spurious valids. A word-level shadow
// memory serves as the reference model. An expected-response queue holds
// {err, rdata} for each command.
module tb_mem_access_initiator;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_request;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_valid;
  logic [31:0] mem_rdata;

  mem_access_initiator #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_ADDR_WIDTH(32), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .mem_request(mem_request), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_valid(mem_valid), .mem_rdata(mem_rdata)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- memory responder ----------------
  logic [31:0] tb_mem  [0:63];
  logic [31:0] ref_mem [0:63];
  int          lat_rd = 0;
  int          lat_wr = 0;
  int          wait_cnt = 0;
  int          lat_cur;
  logic        spur = 1'b0;
  logic        spur_en = 1'b0;

  assign lat_cur   = mem_we ? lat_wr : lat_rd;
  assign mem_valid = mem_request ? (wait_cnt >= lat_cur) : spur;
  assign mem_rdata = mem_request ? tb_mem[mem_addr[5:0]] : 32'hDEAD_BEEF;

  always @(negedge clk) spur = spur_en && ($urandom_range(0, 3) == 0);

  // Monitors: stall counting, writes and protocol rules. The driver reads
  // these counters as snapshots.
  int          req_cyc_total = 0;
  int          wr_total      = 0;
  int          gap_viol      = 0;
  int          addr_viol     = 0;
  logic        done_prev     = 1'b0;
  logic [31:0] last_maddr    = '0;
  logic [31:0] last_wdata    = '0;
  logic [31:0] exp_maddr     = '0;

  always @(posedge clk) begin
    if (!mem_request || mem_valid) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
    if (mem_request) begin
      req_cyc_total <= req_cyc_total + 1;
      last_maddr    <= mem_addr;
      if (mem_addr !== exp_maddr) addr_viol <= addr_viol + 1;
    end
    if (mem_request && mem_we && mem_valid) begin
      tb_mem[mem_addr[5:0]] <= mem_wdata;
      last_wdata            <= mem_wdata;
      wr_total              <= wr_total + 1;
    end
    if (!rst && done_prev && mem_request) gap_viol <= gap_viol + 1;
    done_prev <= mem_request && mem_valid;
  end

  // ---------------- reference model ----------------
  logic [32:0] exp_q[$];

  task automatic model(input logic we, input logic [1:0] size, input logic uns,
                       input logic [7:0] addr, input logic [31:0] wdata,
                       input int lr, input int lw,
                       output int exp_lat, output int exp_wr, output int exp_req);
    int          idx;
    int          sh;
    logic [31:0] word;
    logic [31:0] v;
    logic [31:0] mask;
    idx  = int'(addr) / 4;
    sh   = (int'(addr) % 4) * 8;
    word = ref_mem[idx];
    exp_wr = 0;
    if (size == 2'd3 || (size == 2'd1 && (addr % 2) != 0) || (size == 2'd2 && (addr % 4) != 0)) begin
      exp_q.push_back({1'b1, 32'h0});
      exp_lat = 1; exp_req = 0;
    end else if (!we) begin
      if (lr >= TMO) begin
        exp_q.push_back({1'b1, 32'h0});
        exp_lat = TMO + 1; exp_req = TMO;
      end else begin
        v = word >> sh;
        if (size == 2'd0) begin
          v = v & 32'hFF;
          if (!uns && v >= 32'd128) v = v | 32'hFFFF_FF00;
        end else if (size == 2'd1) begin
          v = v & 32'hFFFF;
          if (!uns && v >= 32'd32768) v = v | 32'hFFFF_0000;
        end
        exp_q.push_back({1'b0, v});
        exp_lat = lr + 2; exp_req = lr + 1;
      end
    end else if (size == 2'd2) begin
      if (lw >= TMO) begin
        exp_q.push_back({1'b1, 32'h0});
        exp_lat = TMO + 1; exp_req = TMO;
      end else begin
        ref_mem[idx] = wdata;
        exp_q.push_back({1'b0, 32'h0});
        exp_lat = lw + 2; exp_req = lw + 1; exp_wr = 1;
      end
    end else begin
      if (lr >= TMO) begin
        exp_q.push_back({1'b1, 32'h0});
        exp_lat = TMO + 1; exp_req = TMO;
      end else if (lr + lw >= TMO) begin
        exp_q.push_back({1'b1, 32'h0});
        exp_lat = TMO + 3; exp_req = TMO + 1;
      end else begin
        mask = ((size == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
        ref_mem[idx] = (word & ~mask) | ((wdata << sh) & mask);
        exp_q.push_back({1'b0, 32'h0});
        exp_lat = lr + lw + 4; exp_req = lr + lw + 2; exp_wr = 1;
      end
    end
  endtask

  // ---------------- driver ----------------
  // Call this task at a negedge. It returns at a negedge after the response
  // handshake.
  task automatic run_cmd(input logic we, input logic [1:0] size, input logic uns,
                         input logic [7:0] addr, input logic [31:0] wdata,
                         input int lr, input int lw, input int hold);
    int          exp_lat, exp_wr, exp_req, cyc, guard, rc0, wr0;
    logic [32:0] exp;
    logic [31:0] held;
    model(we, size, uns, addr, wdata, lr, lw, exp_lat, exp_wr, exp_req);
    lat_rd = lr; lat_wr = lw;
    exp_maddr = {24'h0, addr} >> 2;
    req_we = we; req_size = size; req_unsigned = uns;
    req_addr = {24'h0, addr}; req_wdata = wdata; req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
    check_eq("accept", {31'h0, req_ready}, 32'h1);
    rc0 = req_cyc_total; wr0 = wr_total;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    req_size = 2'($urandom_range(0, 3)); req_we = 1'($urandom_range(0, 1));
    cyc = 1;
    while (!resp_valid && cyc < 100) begin @(negedge clk); cyc++; end
    check_eq("latency", cyc, exp_lat);
    exp = exp_q.pop_front();
    check_eq("resp_err", {31'h0, resp_err}, {31'h0, exp[32]});
    check_eq("resp_rdata", resp_rdata, exp[31:0]);
    held = resp_rdata;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_eq("hold_valid", {31'h0, resp_valid}, 32'h1);
      check_eq("hold_rdata", resp_rdata, held);
      check_eq("hold_err", {31'h0, resp_err}, {31'h0, exp[32]});
      check_eq("hold_req_ready", {31'h0, req_ready}, 32'h0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    check_eq("resp_drop", {31'h0, resp_valid}, 32'h0);
    check_eq("req_cycles", req_cyc_total - rc0, exp_req);
    check_eq("writes", wr_total - wr0, exp_wr);
    check_eq("mem_word", tb_mem[int'(addr) / 4], ref_mem[int'(addr) / 4]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0] sz;
    logic [7:0] ad;
    int         rc0, r, lr, lw;
    for (int i = 0; i < 64; i++) begin
      tb_mem[i]  = $urandom;
      ref_mem[i] = tb_mem[i];
    end
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset values
    check_eq("rst_req_ready", {31'h0, req_ready}, 32'h1);
    check_eq("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check_eq("rst_resp_err", {31'h0, resp_err}, 32'h0);
    check_eq("rst_mem_request", {31'h0, mem_request}, 32'h0);
    check_eq("rst_mem_we", {31'h0, mem_we}, 32'h0);
    check_eq("rst_resp_rdata", resp_rdata, 32'h0);
    check_eq("rst_mem_addr", mem_addr, 32'h0);
    check_eq("rst_mem_wdata", mem_wdata, 32'h0);

    // Directed cases on the word at 0x40
    tb_mem[16] = 32'h8899_AABC; ref_mem[16] = 32'h8899_AABC;
    run_cmd(1'b0, 2'd0, 1'b0, 8'h41, 32'h0, 0, 0, 0);
    check_eq("ld_byte_maddr", last_maddr, 32'h10);
    run_cmd(1'b0, 2'd1, 1'b1, 8'h42, 32'h0, 0, 0, 0);
    run_cmd(1'b0, 2'd1, 1'b0, 8'h42, 32'h0, 1, 0, 0);
    run_cmd(1'b1, 2'd0, 1'b0, 8'h43, 32'h0000_0055, 0, 0, 0);
    check_eq("rmw_wdata", last_wdata, 32'h5599_AABC);
    run_cmd(1'b0, 2'd2, 1'b0, 8'h40, 32'h0, 0, 0, 0);
    run_cmd(1'b0, 2'd2, 1'b0, 8'h42, 32'h0, 0, 0, 0);
    run_cmd(1'b0, 2'd3, 1'b0, 8'h40, 32'h0, 0, 0, 0);
    run_cmd(1'b1, 2'd1, 1'b0, 8'h45, 32'h1234, 0, 0, 0);
    run_cmd(1'b1, 2'd2, 1'b0, 8'h44, 32'hCAFE_F00D, 0, 0, 0);

    // Timeout boundary: a valid in the 16th request cycle still completes
    run_cmd(1'b0, 2'd2, 1'b0, 8'h44, 32'h0, TMO - 1, 0, 0);
    run_cmd(1'b0, 2'd2, 1'b0, 8'h40, 32'h0, 100, 0, 0);
    run_cmd(1'b0, 2'd0, 1'b1, 8'h40, 32'h0, 0, 0, 0);
    run_cmd(1'b1, 2'd0, 1'b0, 8'h46, 32'h77, 0, 100, 0);
    run_cmd(1'b1, 2'd2, 1'b0, 8'h48, 32'h1111_2222, 0, 100, 0);

    // Hold the response for five cycles
    run_cmd(1'b0, 2'd0, 1'b0, 8'h42, 32'h0, 0, 0, 5);

    // Reset in the middle of a read that never completes
    lat_rd = 100; exp_maddr = 32'h20;
    req_we = 1'b0; req_size = 2'd2; req_addr = 32'h80; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rd_active", {31'h0, mem_request}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("mid_rst_mem_request", {31'h0, mem_request}, 32'h0);
    check_eq("mid_rst_mem_addr", mem_addr, 32'h0);
    check_eq("mid_rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check_eq("mid_rst_req_ready", {31'h0, req_ready}, 32'h1);
    rc0 = req_cyc_total;
    repeat (5) begin
      @(negedge clk);
      check_eq("mid_rst_no_resp", {31'h0, resp_valid}, 32'h0);
    end
    check_eq("mid_rst_no_req", req_cyc_total - rc0, 0);

    // Random commands with spurious valids while no request is active
    spur_en = 1'b1;
    for (int n = 0; n < 150; n++) begin
      r  = $urandom_range(0, 9);
      sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      ad = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 9) < 7) begin
        if (sz == 2'd1) ad[0] = 1'b0;
        if (sz == 2'd2) ad[1:0] = 2'b00;
      end
      lr = ($urandom_range(0, 9) == 0) ? $urandom_range(12, 17) : $urandom_range(0, 3);
      lw = ($urandom_range(0, 9) == 0) ? $urandom_range(12, 17) : $urandom_range(0, 3);
      run_cmd(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ad, $urandom,
              lr, lw, $urandom_range(0, 2));
    end
    spur_en = 1'b0;

    check_eq("gap_violations", gap_viol, 0);
    check_eq("addr_violations", addr_viol, 0);
    check_eq("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
